// File: rtl/prog_loader_pkg.sv
// Shared types and frame-field constants for the serial program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_H,
    ST_LEN_L,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_CHK
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;
  localparam int PAR_W  = 2;
  localparam int WORD_W = PAR_W + 2 * BYTE_W;

  // Instruction word layout: {parity[1:0], data[15:8], data[7:0]}.
  function automatic logic [WORD_W-1:0] pack_word(input logic [PAR_W-1:0]  par,
                                                  input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
    return {par, hi, lo};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  import prog_loader_pkg::*;

  logic [BYTE_W-1:0]     rx_data;
  logic                  rx_valid;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_W-1:0]     mem_wdata;
  logic                  mem_we;

  modport master (
    output rx_data,
    output rx_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

endinterface

// File: rtl/prog_loader_timeout.sv
// Restartable inter-byte watchdog: armed by start, reloaded by kick, disarmed by stop.
module loader_timeout
  import prog_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic kick_i,
  input  logic stop_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Loaded with T-1 so the expiry decision lands T-1 cycles after the byte and
  // the resulting error becomes visible exactly T cycles after it.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (stop_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      run_d = 1'b1;
      cnt_d = RELOAD;
    end else if (kick_i) begin
      cnt_d = RELOAD;
    end else if (run_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // A byte arriving on the deadline cycle wins over the expiry.
  assign expired_o = run_q && (cnt_q == CNT_W'(1)) && !kick_i && !start_i;

endmodule

// File: rtl/prog_loader.sv
// Assembles UART bytes into 18-bit instruction words, writes them into the
// instruction BRAM and holds the CPU in reset until the image checksum verifies.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int               CNT_W   = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_WIDTH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [BYTE_W-1:0]   len_h_q, len_h_d;
  logic [BYTE_W-1:0]   sum_q, sum_d;
  logic [PAR_W-1:0]    b0_q, b0_d;
  logic [BYTE_W-1:0]   b1_q, b1_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [LEN_W-1:0]    len_rx;
  logic [BYTE_W-1:0]   sum_rx;
  logic                in_frame;
  logic                tmr_start, tmr_kick, tmr_stop, tmr_expired;

  assign len_rx   = {len_h_q, bus.rx_data};
  assign sum_rx   = sum_q + bus.rx_data;
  assign in_frame = (state_q != ST_IDLE);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .start_i  (tmr_start),
    .kick_i   (tmr_kick),
    .stop_i   (tmr_stop),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    len_h_d   = len_h_q;
    sum_d     = sum_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    tmr_start = 1'b0;
    tmr_kick  = bus.rx_valid && in_frame;

    // The address advances the cycle after the write strobe.
    if (we_q) cnt_d = cnt_q + 1'b1;

    if (in_frame && tmr_expired) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (bus.rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_d   = ST_LEN_H;
            err_d     = 1'b0;
            sum_d     = '0;
            cnt_d     = '0;
            tmr_start = 1'b1;
          end
        end
        ST_LEN_H: begin
          len_h_d = bus.rx_data;
          sum_d   = sum_rx;
          state_d = ST_LEN_L;
        end
        ST_LEN_L: begin
          sum_d = sum_rx;
          if ((len_rx == '0) || (len_rx > MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            len_d   = CNT_W'(len_rx);
            state_d = ST_B0;
          end
        end
        ST_B0: begin
          if (bus.rx_data[BYTE_W-1:PAR_W] != '0) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            b0_d    = bus.rx_data[PAR_W-1:0];
            sum_d   = sum_rx;
            state_d = ST_B1;
          end
        end
        ST_B1: begin
          b1_d    = bus.rx_data;
          sum_d   = sum_rx;
          state_d = ST_B2;
        end
        ST_B2: begin
          we_d    = 1'b1;
          wdata_d = pack_word(b0_q, b1_q, bus.rx_data);
          sum_d   = sum_rx;
          // cnt_q still holds the address of the word being written here.
          state_d = ((cnt_q + 1'b1) == len_q) ? ST_CHK : ST_B0;
        end
        ST_CHK: begin
          if (sum_rx == '0) done_d = 1'b1;
          else              err_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign tmr_stop = (state_d == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      len_h_q <= '0;
      sum_q   <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      len_h_q <= len_h_d;
      sum_q   <= sum_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_addr  = cnt_q[ADDR_WIDTH-1:0];
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign busy          = in_frame;
  assign done          = done_q;
  assign error         = err_q;
  assign cpu_reset     = reset | in_frame | err_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader that sits directly upstream of the PicoBlaze instruction memory (`spartan6_mem`). It takes a byte stream from the UART receiver, assembles 18-bit instruction words, and writes them sequentially into the instruction BRAM through its write port. While a load is in progress it holds the PicoBlaze core in reset. It releases the core only after the image checksum verifies.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: instruction memory address width (1024 words).
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 1_000_000: maximum clk cycles allowed between bytes inside a frame.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid. There is no backpressure; every strobe is consumed.
- `mem_addr`  out  ADDR_WIDTH  write address to the instruction memory.
- `mem_wdata`  out  18  instruction word, `{parity[1:0], data[15:0]}` order = bits [17:0].
- `mem_we`  out  1  one-cycle write strobe; the top level fans it out to all BRAM byte enables.
- `cpu_reset`  out  1  reset to the PicoBlaze core.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse on successful load.
- `error`  out  1  sticky; cleared at the start of the next frame or by `reset`.

## Operation
- Frame format: `SYNC_BYTE`, `LEN_H`, `LEN_L`, then N×(`B0`,`B1`,`B2`), then `CHK`.
  - N = `{LEN_H,LEN_L}`, valid range 1..2**ADDR_WIDTH.
  - Word = `{B0[1:0],B1,B2}`; `B0[7:2]` must be 0.
  - Checksum rule: 8-bit sum of `LEN_H`, `LEN_L`, all data bytes and `CHK` must equal 8'h00.
- FSM states: IDLE, LEN_H, LEN_L, B0, B1, B2, CHK.
  - IDLE: a `SYNC_BYTE` moves to LEN_H. It clears `error`, the checksum accumulator and the word counter. Any other byte is ignored.
  - LEN_H → LEN_L. LEN_L validates N: if N = 0 or N > 2**ADDR_WIDTH, raise error and go to IDLE; otherwise go to B0.
  - B0: a nonzero `B0[7:2]` raises error and returns to IDLE; otherwise go to B1.
  - B1 → B2.
  - B2 issues the write. The next state is B0 if words remain, else CHK.
  - CHK: a good sum pulses `done` and goes to IDLE; a bad sum raises error and goes to IDLE.
- Timeout: the inter-byte counter runs in every state except IDLE and restarts on each `rx_valid`. On reaching `TIMEOUT_CYCLES`, raise error and go to IDLE.
- `cpu_reset` = 1 when `busy`, or when `error` is set, or during `reset`. It is 0 in IDLE after a good load or after reset with no error (the BRAM INIT image runs).
- A `SYNC_BYTE` received mid-frame is treated as data; it does not restart the frame.
- Word counter is ADDR_WIDTH+1 bits wide. `mem_addr` = counter[ADDR_WIDTH-1:0], starting at 0. A full 1024-word load writes addresses 0..1023 with no wrap.

## Timing
- Reset values: `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `cpu_reset`=1, `busy`=0, `done`=0, `error`=0. The state is IDLE. On the first cycle after reset deasserts, `cpu_reset`=0.
- Reset asserted mid-frame aborts the frame immediately. Words already written stay in memory; `error` is not set.
- A byte accepted at cycle N updates the state at N+1.
- For the `B2` byte at cycle N: `mem_we`=1 at N+1 only, with `mem_addr`/`mem_wdata` stable that cycle. The counter increments at N+2.
- For the `CHK` byte at cycle N: `done` (or `error`) is valid at N+1. `busy` falls at N+1. `cpu_reset` falls at N+1 on success.
- `busy` rises the cycle after the `SYNC_BYTE` strobe.
- A timeout fires exactly `TIMEOUT_CYCLES` cycles after the last accepted byte.

## Structure
- `prog_loader_pkg`: the state enum, the `SYNC_BYTE` default, and the frame-field width constants.
- Sub-module `loader_timeout`: a restartable down-counter with `start`/`kick`/`expired`. It is instantiated once.
- All other logic (FSM, word assembly, checksum accumulation, write strobe) lives in `prog_loader`.

## Test plan
- Good 2-word frame A5 00 02 | 03 12 34 | 00 AB CD | CHK=(−(00+02+03+12+34+00+AB+CD))&FF:
  - mem writes (0,18'h31234) and (1,18'h0ABCD).
  - `done` pulses once; `cpu_reset` ends at 0.
- Same frame with CHK+1:
  - both writes occur.
  - `error`=1 and `cpu_reset` stays 1 until the next good frame, which clears both.
- LEN 00 00, and separately LEN 04 01:
  - error at LEN_L+1, with no `mem_we`.
- `B0`=8'h04:
  - error, with no write for that word.
- Stall after `LEN_L` for `TIMEOUT_CYCLES` (test uses 100):
  - error at exactly cycle 100.
  - A stall of 99 cycles followed by data continues normally.
- 1024-word frame:
  - the last write goes to address 1023, then `done`.
  - `reset` pulsed mid-frame instead: state returns to IDLE, `busy`=0, `error`=0.
